// File: rtl/sn76489_pkg.sv
// Shared types and defaults for the SN76489 PSG blocks.
package sn76489_pkg;

   localparam int unsigned PSG_WAIT_TICKS_DEF = 32;
   localparam int unsigned PSG_CHAN_W         = 2;
   localparam int unsigned PSG_NUM_CHAN       = 4;
   localparam int unsigned PSG_BYTE_W         = 8;
   localparam int unsigned PSG_CNT_W          = 8;

   // Channel addressed by a latch byte (d_i[1:2]).
   typedef enum logic [PSG_CHAN_W-1:0] {
      CH_TONE1 = 2'b00,
      CH_TONE2 = 2'b01,
      CH_TONE3 = 2'b10,
      CH_NOISE = 2'b11
   } psg_chan_t;

   // Write-port handshake state.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_ISSUE = 2'b01,
      ST_BUSY  = 2'b10
   } bus_state_t;

endpackage : sn76489_pkg

// File: rtl/sn76489_bus_ctrl.sv
// SN76489 CPU write port: decodes latch/data bytes, steers each accepted
// byte to one channel block and drives READY low for a fixed wait period.
//   clock_i, res_n_i      : clock, async active-low reset
//   clk_en_i              : PSG clock enable shared with channel blocks
//   ce_n_i, we_n_i, d_i   : host bus strobe and byte (d_i[0] is MSB)
//   ready_o               : high while a write can be accepted
//   tone*_we_o, noise_we_o: per-channel write enables (one-hot or zero)
//   r2_o, d_o             : register select and accepted byte for channels
//   overrun_o             : sticky, a strobe arrived while not idle
module sn76489_bus_ctrl
   import sn76489_pkg::*;
#(
   parameter int unsigned WAIT_TICKS = PSG_WAIT_TICKS_DEF
) (
   input  logic               clock_i,
   input  logic               res_n_i,
   input  logic               clk_en_i,
   input  logic               ce_n_i,
   input  logic               we_n_i,
   input  logic [0:7]         d_i,
   output logic               ready_o,
   output logic               tone1_we_o,
   output logic               tone2_we_o,
   output logic               tone3_we_o,
   output logic               noise_we_o,
   output logic               r2_o,
   output logic [0:7]         d_o,
   output logic               overrun_o
);

   bus_state_t                    state_q, state_d;
   logic                          strb_q, strb_d;
   psg_chan_t                     chan_q, chan_d;
   logic                          type_q, type_d;
   logic [PSG_NUM_CHAN-1:0]       we_q, we_d;
   logic                          r2_q, r2_d;
   logic [0:PSG_BYTE_W-1]         dout_q, dout_d;
   logic [PSG_CNT_W-1:0]          cnt_q, cnt_d;
   logic                          ovr_q, ovr_d;
   logic                          ready_q, ready_d;

   logic                          strb_c;
   logic                          accept_c;
   psg_chan_t                     new_chan_c;
   logic                          new_type_c;

   // State register; strb_q resets high so a strobe held through reset
   // release must be dropped and reasserted before it is accepted.
   always_ff @(posedge clock_i or negedge res_n_i) begin
      if (!res_n_i) begin
         state_q <= ST_IDLE;
         strb_q  <= 1'b1;
         chan_q  <= CH_TONE1;
         type_q  <= 1'b0;
         we_q    <= '0;
         r2_q    <= 1'b0;
         dout_q  <= '0;
         cnt_q   <= '0;
         ovr_q   <= 1'b0;
         ready_q <= 1'b1;
      end else begin
         state_q <= state_d;
         strb_q  <= strb_d;
         chan_q  <= chan_d;
         type_q  <= type_d;
         we_q    <= we_d;
         r2_q    <= r2_d;
         dout_q  <= dout_d;
         cnt_q   <= cnt_d;
         ovr_q   <= ovr_d;
         ready_q <= ready_d;
      end
   end

   // Next-state and output decode.
   always_comb begin
      state_d    = state_q;
      chan_d     = chan_q;
      type_d     = type_q;
      we_d       = we_q;
      r2_d       = r2_q;
      dout_d     = dout_q;
      cnt_d      = cnt_q;
      ovr_d      = ovr_q;

      strb_c     = ~ce_n_i & ~we_n_i;
      strb_d     = strb_c;
      accept_c   = strb_c & ~strb_q;

      // Latch bytes retarget the port; data bytes reuse the current latch.
      new_chan_c = d_i[0] ? psg_chan_t'(d_i[1:2]) : chan_q;
      new_type_c = d_i[0] ? d_i[3] : type_q;

      case (state_q)
         ST_IDLE: begin
            if (accept_c) begin
               state_d = ST_ISSUE;
               chan_d  = new_chan_c;
               type_d  = new_type_c;
               we_d    = PSG_NUM_CHAN'(1) << new_chan_c;
               r2_d    = new_type_c;
               dout_d  = d_i;
            end
         end
         ST_ISSUE: begin
            if (accept_c) ovr_d = 1'b1;
            // Channels sample on this same enabled edge.
            if (clk_en_i) begin
               state_d = ST_BUSY;
               cnt_d   = PSG_CNT_W'(WAIT_TICKS - 1);
               we_d    = '0;
            end
         end
         ST_BUSY: begin
            if (accept_c) ovr_d = 1'b1;
            if (clk_en_i) begin
               if (cnt_q == '0) state_d = ST_IDLE;
               else             cnt_d   = cnt_q - PSG_CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            we_d    = '0;
         end
      endcase

      ready_d = (state_d == ST_IDLE);
   end

   assign ready_o    = ready_q;
   assign tone1_we_o = we_q[CH_TONE1];
   assign tone2_we_o = we_q[CH_TONE2];
   assign tone3_we_o = we_q[CH_TONE3];
   assign noise_we_o = we_q[CH_NOISE];
   assign r2_o       = r2_q;
   assign d_o        = dout_q;
   assign overrun_o  = ovr_q;

endmodule : sn76489_bus_ctrl

// File: tb/tb_sn76489_bus_ctrl.sv
// Self-checking bench for sn76489_bus_ctrl: scoreboard of expected channel
// writes, READY timing, overrun, gated enable and reset-in-busy.
module tb_sn76489_bus_ctrl;

   typedef struct {
      logic [1:0] chan;
      logic       r2;
      logic [7:0] d;
   } exp_t;

   logic       clock_i  = 1'b0;
   logic       res_n_i  = 1'b0;
   logic       clk_en_i = 1'b1;
   logic       ce_n_i   = 1'b1;
   logic       we_n_i   = 1'b1;
   logic [0:7] d_i      = '0;
   logic       ready_o;
   logic       tone1_we_o, tone2_we_o, tone3_we_o, noise_we_o;
   logic       r2_o;
   logic [0:7] d_o;
   logic       overrun_o;

   int         total = 0;
   int         bad   = 0;
   exp_t       sb_q[$];
   logic [1:0] m_chan = 2'b00;
   logic       m_type = 1'b0;
   logic [3:0] we_prev = '0;
   logic [15:0] lfsr;
   int         gate = 0;
   int         ph = 0;

   sn76489_bus_ctrl #(.WAIT_TICKS(32)) dut (
      .clock_i   (clock_i),
      .res_n_i   (res_n_i),
      .clk_en_i  (clk_en_i),
      .ce_n_i    (ce_n_i),
      .we_n_i    (we_n_i),
      .d_i       (d_i),
      .ready_o   (ready_o),
      .tone1_we_o(tone1_we_o),
      .tone2_we_o(tone2_we_o),
      .tone3_we_o(tone3_we_o),
      .noise_we_o(noise_we_o),
      .r2_o      (r2_o),
      .d_o       (d_o),
      .overrun_o (overrun_o)
   );

   always #5 clock_i = ~clock_i;

   // Enable generator: tied high, or one cycle in four when gated.
   initial begin
      forever begin
         @(posedge clock_i);
         #1;
         clk_en_i = (gate == 0) || (ph == 0);
         ph = (ph + 1) % 4;
      end
   end

   // Minimal noise-block stand-in: control write reseeds its LFSR.
   always_ff @(posedge clock_i or negedge res_n_i) begin
      if (!res_n_i) lfsr <= 16'h8000;
      else if (clk_en_i) begin
         if (noise_we_o && !r2_o) lfsr <= 16'h0001;
         else                     lfsr <= {lfsr[0] ^ lfsr[3], lfsr[15:1]};
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
      end
   endtask

   // Scoreboard monitor: each rising write enable consumes one expectation.
   always @(negedge clock_i) begin
      logic [3:0] we_v;
      exp_t       e;
      we_v = {noise_we_o, tone3_we_o, tone2_we_o, tone1_we_o};
      if ($countones(we_v) > 1) chk("we_onehot", 32'(we_v), 32'(we_prev));
      if (we_v != 4'b0 && we_prev == 4'b0) begin
         if (sb_q.size() == 0) chk("we_unexpected", 32'(we_v), 32'h0);
         else begin
            e = sb_q.pop_front();
            chk("we_chan", 32'(we_v), 32'(4'b0001 << e.chan));
            chk("r2", 32'(r2_o), 32'(e.r2));
            chk("d_o", 32'(d_o), 32'(e.d));
         end
      end
      if (we_prev[3] && !we_v[3] && res_n_i) chk("lfsr_reseed", 32'(lfsr), 32'h1);
      we_prev = we_v;
   end

   // Wait (bounded) for READY, then strobe for one clock edge.
   task automatic do_write(input logic [7:0] b, input bit expect_accept);
      exp_t e;
      int   n;
      n = 0;
      @(negedge clock_i);
      while (!ready_o && n < 2000) begin
         @(negedge clock_i);
         n++;
      end
      if (!ready_o) chk("ready_timeout", 32'(ready_o), 32'h1);
      if (expect_accept) begin
         if (b[7]) begin
            m_chan = b[6:5];
            m_type = b[4];
         end
         e.chan = m_chan;
         e.r2   = m_type;
         e.d    = b;
         sb_q.push_back(e);
      end
      d_i    = b;
      ce_n_i = 1'b0;
      we_n_i = 1'b0;
      @(posedge clock_i);
      #1;
      ce_n_i = 1'b1;
      we_n_i = 1'b1;
   endtask

   // READY low length, BUSY enabled ticks and write-enable span of the
   // write just issued.
   task automatic measure(output int low, output int ticks, output int span);
      low = 0; ticks = 0; span = 0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clock_i);
         if (ready_o) break;
         low++;
         if (tone1_we_o | tone2_we_o | tone3_we_o | noise_we_o) span++;
         else if (clk_en_i) ticks++;
      end
   endtask

   initial begin
      int low, ticks, span;

      repeat (3) @(negedge clock_i);
      chk("rst_ready", 32'(ready_o), 32'h1);
      chk("rst_we", 32'({noise_we_o, tone3_we_o, tone2_we_o, tone1_we_o}), 32'h0);
      chk("rst_d_o", 32'(d_o), 32'h0);
      chk("rst_r2", 32'(r2_o), 32'h0);
      chk("rst_ovr", 32'(overrun_o), 32'h0);
      res_n_i = 1'b1;
      repeat (2) @(negedge clock_i);

      // Latch 0x9F: tone1 attenuator, READY low WAIT_TICKS+1 cycles.
      do_write(8'h9F, 1'b1);
      measure(low, ticks, span);
      chk("latch_low", 32'(low), 32'd33);
      chk("latch_span", 32'(span), 32'd1);
      chk("latch_ticks", 32'(ticks), 32'd32);

      // Latch then data, data issued in first READY cycle.
      do_write(8'h85, 1'b1);
      do_write(8'h3A, 1'b1);
      measure(low, ticks, span);
      chk("data_low", 32'(low), 32'd33);

      // Noise control write.
      do_write(8'hE5, 1'b1);
      measure(low, ticks, span);

      // Overrun: re-strobe 5 cycles into the write.
      do_write(8'hC0, 1'b1);
      repeat (5) @(posedge clock_i);
      #1;
      d_i = 8'h00; ce_n_i = 1'b0; we_n_i = 1'b0;
      @(posedge clock_i);
      #1;
      ce_n_i = 1'b1; we_n_i = 1'b1;
      @(negedge clock_i);
      chk("ovr_set", 32'(overrun_o), 32'h1);
      chk("ovr_ready", 32'(ready_o), 32'h0);
      measure(low, ticks, span);

      // Gated enable: data byte to tone3 (latched by 0xC0).
      gate = 1;
      do_write(8'h0F, 1'b1);
      measure(low, ticks, span);
      chk("gate_span_ok", 32'(span >= 1 && span <= 4), 32'h1);
      chk("gate_ticks", 32'(ticks), 32'd32);
      chk("ovr_sticky", 32'(overrun_o), 32'h1);
      gate = 0;

      // Reset in BUSY with strobe held across release.
      do_write(8'h9F, 1'b1);
      repeat (11) @(negedge clock_i);
      chk("busy_ready", 32'(ready_o), 32'h0);
      d_i = 8'h9F; ce_n_i = 1'b0; we_n_i = 1'b0;
      #1;
      res_n_i = 1'b0;
      m_chan = 2'b00;
      m_type = 1'b0;
      #1;
      chk("rstb_ready", 32'(ready_o), 32'h1);
      chk("rstb_ovr", 32'(overrun_o), 32'h0);
      chk("rstb_d_o", 32'(d_o), 32'h0);
      @(posedge clock_i);
      #1;
      res_n_i = 1'b1;
      repeat (5) @(negedge clock_i);
      chk("held_ready", 32'(ready_o), 32'h1);
      chk("held_we", 32'({noise_we_o, tone3_we_o, tone2_we_o, tone1_we_o}), 32'h0);
      ce_n_i = 1'b1; we_n_i = 1'b1;
      // Data byte after reset goes to tone1 tone-register.
      do_write(8'h05, 1'b1);
      measure(low, ticks, span);
      chk("post_rst_low", 32'(low), 32'd33);

      repeat (3) @(negedge clock_i);
      chk("sb_empty", 32'(sb_q.size()), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_sn76489_bus_ctrl

// File: doc/sn76489_bus_ctrl.md
# sn76489_bus_ctrl

CPU write-port controller for the SN76489 PSG. It accepts byte writes from the host bus and decodes the latch/data byte protocol. It steers each byte to one of the four channel blocks (tone 1–3, noise) as a `we`/`r2`/data bundle. It also drives the chip's READY handshake, holding READY low for a fixed wait period after every accepted write. It sits between the bus glue and the three tone generators plus the noise generator.

## Interface
Parameters:
- `WAIT_TICKS`, default 32: number of `clk_en_i` ticks that READY stays low after the write is issued; legal range 1–255.

Ports:
- `clock_i`  in  1  system clock.
- `res_n_i`  in  1  reset; asynchronous, active-low.
- `clk_en_i`  in  1  PSG clock enable, shared with all channel blocks.
- `ce_n_i`  in  1  chip enable, active-low.
- `we_n_i`  in  1  write enable, active-low.
- `d_i`  in  [0:7]  host data; `d_i[0]` is the MSB.
- `ready_o`  out  1  high when the port can accept a write.
- `tone1_we_o`, `tone2_we_o`, `tone3_we_o`, `noise_we_o`  out  1 each  per-channel write enables; at most one is high at a time.
- `r2_o`  out  1  register select forwarded to channels: 0 = tone/control, 1 = attenuator.
- `d_o`  out  [0:7]  registered copy of the accepted byte.
- `overrun_o`  out  1  sticky; set when a write strobe arrives while the port is not IDLE.

## Operation
- Strobe: `strb = ~ce_n_i & ~we_n_i`. It is registered as `strb_q`. An accept edge is `strb & ~strb_q`.
- A write is accepted only in IDLE on an accept edge.
- An accept edge in ISSUE or BUSY is dropped and sets `overrun_o`.
- Latch byte (`d_i[0]=1`):
  - latched channel ← `d_i[1:2]`; 00 = tone1, 01 = tone2, 10 = tone3, 11 = noise.
  - latched type ← `d_i[3]`.
- Data byte (`d_i[0]=0`): latch is unchanged.
- Both byte kinds are forwarded to the currently latched channel. `r2_o` = latched type, as updated by this byte. `d_o` = the byte, unchanged; channel blocks decode their own fields.
- A noise-control write (latch or data) resets the noise LFSR. That behaviour is inside the noise block; this block only has to issue `noise_we_o` with `r2_o=0`.
- FSM:
  - IDLE → ISSUE on an accepted edge. The cycle that enters ISSUE also registers `d_o`, `r2_o`, the channel `we`, and the latch update.
  - ISSUE: `we` is held. ISSUE → BUSY on the first cycle with `clk_en_i=1`; the channel blocks sample on that same edge. On entering BUSY, counter ← `WAIT_TICKS-1` and `we` clears.
  - BUSY: the counter decrements on each `clk_en_i` tick. BUSY → IDLE on a `clk_en_i` tick when counter = 0.
- `ready_o` = (state == IDLE), registered.
- Reset values:
  - state IDLE, `ready_o=1`, all `we=0`, `r2_o=0`, `d_o=0x00`, `overrun_o=0`.
  - latch = tone1 / type 0.
  - `strb_q=1`, so a strobe held asserted through reset release is not accepted until it is released and reasserted.
- Async reset mid-write aborts immediately to the reset state. A pending `we` is lost.

## Timing
- Accept edge sampled at edge T. At T+1: `ready_o=0`, `we`/`r2_o`/`d_o` valid.
- With `clk_en_i` tied high:
  - `we` is high exactly 1 cycle.
  - `ready_o` is low `WAIT_TICKS+1` cycles; it rises at T+`WAIT_TICKS`+2.
- With gated `clk_en_i`, `we` stays high until the first enabled edge. The BUSY length is `WAIT_TICKS` enabled ticks.
- Accept edge in the same cycle that BUSY exits: state is still BUSY, so the write is dropped with overrun.
- Back-to-back: the next accept edge is honoured in the first cycle that `ready_o=1`.

## Structure
- Shared package `sn76489_pkg` holds:
  - `psg_chan_t` enum (`CH_TONE1`, `CH_TONE2`, `CH_TONE3`, `CH_NOISE`, 2-bit);
  - `bus_state_t` (`ST_IDLE`, `ST_ISSUE`, `ST_BUSY`);
  - `PSG_WAIT_TICKS_DEF` = 32.
- Single module. The wait counter is 8-bit and inline; no sub-module is warranted.

## Test plan
- Latch write: reset, write 0x9F → `tone1_we_o` high 1 cycle, `r2_o=1`, `d_o=0x9F`; `ready_o` low 33 cycles (`clk_en_i`=1).
- Latch then data: write 0x85 then 0x3A after READY → two `tone1_we_o` pulses, both `r2_o=0`, `d_o`=0x85 then 0x3A.
- Noise control: write 0xE5 → `noise_we_o`, `r2_o=0`, `d_o=0xE5`; the attached noise block shows LFSR = 0x0001 after the edge.
- Overrun: write 0xC0, re-strobe 5 cycles later → no second `we`, `overrun_o=1` until reset.
- Gated enable: `clk_en_i` high 1 cycle in 4 → `we` spans up to 4 cycles; READY low for 32 enabled ticks.
- Reset in BUSY: assert `res_n_i` low at cycle 10 of BUSY → `ready_o=1` immediately; a strobe held low through release is ignored until re-asserted.
